// File: rtl/csr_tohost_monitor.sv
// Watches the registered CSR write stream for tohost writes, buffers them in a small FIFO
// drained over valid/ready, and decodes the RISC-V pass/fail termination convention.
module csr_tohost_monitor #(
    parameter logic [11:0] TOHOST_ADDR = 12'h51E,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [30:0] test_num,
    output logic        overflow,
    output logic [15:0] wr_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_latch_test;

    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic [30:0]       r_test_num;
    logic              r_overflow;
    logic [15:0]       r_wr_count;

    logic              w_qual;
    logic              w_full;
    logic              w_pop;
    logic              w_push_ok;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [31:0]       w_head_nxt;

    assign w_qual       = wr_en && (wr_addr == TOHOST_ADDR) && (wr_data != 32'd0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_pop        = r_out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok    = w_qual && (!w_full || w_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_nxt  = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

    // The next head is the incoming word only when the FIFO holds nothing else after the pop.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = wr_data;
        end
    end

    // NOTE: storage carries no reset; pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_overflow  <= 1'b0;
            r_wr_count  <= 16'd0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push_ok);
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_out_data <= w_head_nxt;
            end
            if (w_qual && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_qual && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Termination decoding sees every qualifying write, including ones dropped on overflow.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_test = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_qual) begin
                    if (wr_data == 32'd1) begin
                        w_state_nxt = ST_PASS;
                    end else if (wr_data[0]) begin
                        w_state_nxt  = ST_FAIL;
                        w_latch_test = 1'b1;
                    end
                end
            end
            ST_PASS: w_state_nxt = ST_PASS;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_test_num <= 31'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_test) begin
                r_test_num <= wr_data[31:1];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = (r_state != ST_RUN);
    assign pass      = (r_state == ST_PASS);
    assign fail      = (r_state == ST_FAIL);
    assign test_num  = r_test_num;
    assign overflow  = r_overflow;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_csr_tohost_monitor.sv
// Directed bench for csr_tohost_monitor: filtering, latency, pass/fail decode,
// overflow with pointer wrap, and reset in the middle of a drain.
module tb_csr_tohost_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        done;
    logic        pass;
    logic        fail;
    logic [30:0] test_num;
    logic        overflow;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    csr_tohost_monitor #(
        .TOHOST_ADDR (12'h51E),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .test_num  (test_num),
        .overflow  (overflow),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Outputs are sampled 1 ns after the edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [11:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = 12'h000;
        wr_data = 32'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " out_data"},  out_data,           32'd0);
        check({tag, " done"},      {31'd0, done},      32'd0);
        check({tag, " pass"},      {31'd0, pass},      32'd0);
        check({tag, " fail"},      {31'd0, fail},      32'd0);
        check({tag, " overflow"},  {31'd0, overflow},  32'd0);
        check({tag, " test_num"},  {1'b0, test_num},   32'd0);
        check({tag, " wr_count"},  {16'd0, wr_count},  32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
        check_reset("rst");

        // Filtering: wrong address, zero data, strobe low.
        write(12'h300, 32'd1);
        tick();
        write(12'h51E, 32'd0);
        tick();
        wr_en   = 1'b0;
        wr_addr = 12'h51E;
        wr_data = 32'd5;
        tick();
        idle();
        check("filt out_valid", {31'd0, out_valid}, 32'd0);
        check("filt wr_count",  {16'd0, wr_count},  32'd0);
        check("filt done",      {31'd0, done},      32'd0);

        // Single write visible one cycle later.
        write(12'h51E, 32'h0000_0040);
        tick();
        idle();
        check("lat out_valid", {31'd0, out_valid}, 32'd1);
        check("lat out_data",  out_data,           32'h40);
        check("lat wr_count",  {16'd0, wr_count},  32'd1);
        check("lat done",      {31'd0, done},      32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop1 out_valid", {31'd0, out_valid}, 32'd0);
        check("pop1 out_data",  out_data,           32'h40);

        // Pass, then a later odd write must not change status.
        write(12'h51E, 32'd1);
        tick();
        idle();
        check("pass done", {31'd0, done}, 32'd1);
        check("pass pass", {31'd0, pass}, 32'd1);
        check("pass fail", {31'd0, fail}, 32'd0);
        write(12'h51E, 32'd7);
        tick();
        idle();
        check("pass7 pass",     {31'd0, pass},     32'd1);
        check("pass7 fail",     {31'd0, fail},     32'd0);
        check("pass7 test_num", {1'b0, test_num},  32'd0);
        check("pass7 wr_count", {16'd0, wr_count}, 32'd3);
        check("pass7 head",     out_data,          32'd1);
        out_ready = 1'b1;
        tick();
        check("drain head7", out_data, 32'd7);
        tick();
        out_ready = 1'b0;
        check("drain empty", {31'd0, out_valid}, 32'd0);

        // Fail with test number 5, then a pass value is ignored.
        do_reset();
        check_reset("rst2");
        write(12'h51E, 32'h0000_000B);
        tick();
        idle();
        check("fail fail",     {31'd0, fail},    32'd1);
        check("fail done",     {31'd0, done},    32'd1);
        check("fail pass",     {31'd0, pass},    32'd0);
        check("fail test_num", {1'b0, test_num}, 32'd5);
        write(12'h51E, 32'd1);
        tick();
        idle();
        check("fail1 fail",     {31'd0, fail},     32'd1);
        check("fail1 pass",     {31'd0, pass},     32'd0);
        check("fail1 test_num", {1'b0, test_num},  32'd5);
        check("fail1 wr_count", {16'd0, wr_count}, 32'd2);

        // Overflow: five pushes into a depth-4 FIFO with the host stalled.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            write(12'h51E, 32'(i));
            tick();
        end
        check("ovf4 overflow", {31'd0, overflow}, 32'd0);
        write(12'h51E, 32'd5);
        tick();
        idle();
        check("ovf5 overflow", {31'd0, overflow}, 32'd1);
        check("ovf5 wr_count", {16'd0, wr_count}, 32'd5);
        check("ovf5 head",     out_data,          32'd1);
        tick();
        check("stall hold", out_data, 32'd1);
        out_ready = 1'b1;
        tick();
        check("ovf pop a", out_data, 32'd2);
        tick();
        check("ovf pop b", out_data, 32'd3);
        tick();
        check("ovf pop c", out_data, 32'd4);
        tick();
        check("ovf empty valid", {31'd0, out_valid}, 32'd0);
        check("ovf empty data",  out_data,           32'd4);

        // Refill to full, then push while popping: pointers wrap around.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write(12'h51E, 32'hA + 32'(i));
            tick();
        end
        check("full head", out_data, 32'hA);
        write(12'h51E, 32'd6);
        out_ready = 1'b1;
        tick();
        idle();
        check("pp head",     out_data,          32'hB);
        check("pp wr_count", {16'd0, wr_count}, 32'd10);
        tick();
        check("wrap c", out_data, 32'hC);
        tick();
        check("wrap d", out_data, 32'hD);
        tick();
        check("wrap 6", out_data, 32'd6);
        tick();
        check("wrap empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset with three entries queued and a failed status.
        do_reset();
        write(12'h51E, 32'h0000_000B);
        tick();
        write(12'h51E, 32'd2);
        tick();
        write(12'h51E, 32'd4);
        tick();
        idle();
        check("mid fail",     {31'd0, fail},      32'd1);
        check("mid valid",    {31'd0, out_valid}, 32'd1);
        check("mid wr_count", {16'd0, wr_count},  32'd3);
        do_reset();
        check_reset("rst3");
        out_ready = 1'b1;
        tick();
        check("post valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
